// File: rtl/space_invaders_pkg.sv
// Shared types and constants for the space-invaders bullet logic.
//   bullet_state_e      : bullet controller FSM states
//   SCREEN_W / SCREEN_H : visible VGA area in pixels
//   DEF_*               : default values for bullet_controller parameters
//   sat_inc8            : 8-bit increment that sticks at 255
package space_invaders_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int DEF_BULLET_STEP     = 4;
  localparam int DEF_PLAYER_Y        = 440;
  localparam int DEF_BULLET_LEN      = 4;
  localparam int DEF_COOLDOWN_FRAMES = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLY      = 2'd1,
    ST_COOLDOWN = 2'd2
  } bullet_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the VGA vertical sync into the system clock domain and turns each
// rising edge into a single-cycle tick.
//   clk       : system clock
//   rst       : asynchronous, active-high reset
//   frame_clk : vertical sync, asynchronous to clk
//   tick      : one clk cycle high per synchronized rising edge
module frame_tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic frame_clk,
  output logic tick
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       prev_q, prev_d;
  logic [1:0] fill_q, fill_d;

  // fill_q counts the cycles since reset release. Until the edge flop holds a
  // synchronized sample, a frame_clk that was already high at release would
  // look like a rising edge, so ticks are held off until fill_q saturates.
  always_comb begin
    sync1_d = frame_clk;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    fill_d  = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      fill_q  <= 2'd0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      fill_q  <= fill_d;
    end
  end

  assign tick = sync2_q & ~prev_q & (fill_q == 2'd3);

endmodule

// File: rtl/bullet_controller.sv
// Player bullet controller: launches a bullet on the fire key, moves it up
// one step per frame, ends the flight on a hit or at the top of the screen,
// and enforces a cooldown before the next shot.
//   Clk       : system clock
//   Reset     : asynchronous, active-high reset
//   frame_clk : VGA vertical sync, asynchronous to Clk
//   fire      : fire key level
//   start     : start screen active, clears the game
//   hit       : one-cycle pulse, bullet struck an enemy
//   playerX   : column the bullet launches from
//   bullet_in : bullet visible
//   bulletX   : bullet column
//   bulletY   : bullet top row
//   hit_count : saturating count of enemies hit
//   busy      : bullet flying or cooling down
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | no bullet; launch on tick when fire held and armed
// ST_FLY      | bullet visible, rises BULLET_STEP pixels per tick
// ST_COOLDOWN | bullet gone, waiting cnt ticks before returning to idle
module bullet_controller
  import space_invaders_pkg::*;
#(
  parameter int BULLET_STEP     = DEF_BULLET_STEP,
  parameter int PLAYER_Y        = DEF_PLAYER_Y,
  parameter int BULLET_LEN      = DEF_BULLET_LEN,
  parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic       start,
  input  logic       hit,
  input  logic [9:0] playerX,
  output logic       bullet_in,
  output logic [9:0] bulletX,
  output logic [9:0] bulletY,
  output logic [7:0] hit_count,
  output logic       busy
);

  localparam int CNT_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [9:0]       LAUNCH_Y = 10'(PLAYER_Y - BULLET_LEN);
  localparam logic [9:0]       STEP_V   = 10'(BULLET_STEP);
  localparam logic [CNT_W-1:0] CD_LOAD  = CNT_W'(COOLDOWN_FRAMES);

  logic tick;

  frame_tick_sync u_frame_tick_sync (
    .clk       (Clk),
    .rst       (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  bullet_state_e    state_q, state_d;
  logic             bullet_in_q, bullet_in_d;
  logic [9:0]       bullet_x_q, bullet_x_d;
  logic [9:0]       bullet_y_q, bullet_y_d;
  logic [7:0]       hit_count_q, hit_count_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;

  always_comb begin
    state_d     = state_q;
    bullet_in_d = bullet_in_q;
    bullet_x_d  = bullet_x_q;
    bullet_y_d  = bullet_y_q;
    hit_count_d = hit_count_q;
    cnt_d       = cnt_q;
    // Releasing fire on any frame re-arms, so a held key fires only once.
    armed_d     = armed_q | (tick & ~fire);

    if (start) begin
      state_d     = ST_IDLE;
      bullet_in_d = 1'b0;
      hit_count_d = 8'd0;
      armed_d     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tick && fire && armed_q) begin
            bullet_x_d  = playerX;
            bullet_y_d  = LAUNCH_Y;
            armed_d     = 1'b0;
            bullet_in_d = 1'b1;
            state_d     = ST_FLY;
          end
        end
        ST_FLY: begin
          // A hit on the same cycle as a tick ends the flight without moving.
          if (hit) begin
            bullet_in_d = 1'b0;
            hit_count_d = sat_inc8(hit_count_q);
            cnt_d       = CD_LOAD;
            state_d     = ST_COOLDOWN;
          end else if (tick) begin
            if (bullet_y_q < STEP_V) begin
              bullet_in_d = 1'b0;
              cnt_d       = CD_LOAD;
              state_d     = ST_COOLDOWN;
            end else begin
              bullet_y_d = bullet_y_q - STEP_V;
            end
          end
        end
        ST_COOLDOWN: begin
          if (tick) begin
            if (cnt_q <= CNT_W'(1)) begin
              state_d = ST_IDLE;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        default: begin
          state_d     = ST_IDLE;
          bullet_in_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      bullet_in_q <= 1'b0;
      bullet_x_q  <= 10'd0;
      bullet_y_q  <= 10'd0;
      hit_count_q <= 8'd0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      armed_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      bullet_in_q <= bullet_in_d;
      bullet_x_q  <= bullet_x_d;
      bullet_y_q  <= bullet_y_d;
      hit_count_q <= hit_count_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
    end
  end

  assign bullet_in = bullet_in_q;
  assign bulletX   = bullet_x_q;
  assign bulletY   = bullet_y_q;
  assign hit_count = hit_count_q;
  assign busy      = busy_q;

endmodule
